// File: rtl/key_op_capture.sv
// Calculator input stage: syncs and debounces KEY, captures one operator press plus SW operands.
// Optional HOLD_TIMEOUT_EN macro adds an expiry timer on the held operation.
module key_op_capture #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 250_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [1:0] op_sel,
  output logic       op_valid,
  output logic       op_strobe
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST_M1 = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  logic [3:0]       key_meta_q, key_meta_d;
  logic [3:0]       key_sync_q, key_sync_d;
  logic [9:0]       sw_meta_q,  sw_meta_d;
  logic [9:0]       sw_sync_q,  sw_sync_d;
  logic [3:0]       key_db_q,   key_db_d;
  logic [3:0]       key_prev_q, key_prev_d;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  state_t           state_q, state_d;
  logic [3:0]       op_a_q, op_a_d;
  logic [3:0]       op_b_q, op_b_d;
  logic [1:0]       op_sel_q, op_sel_d;
  logic             op_valid_q, op_valid_d;
  logic             op_strobe_q, op_strobe_d;

  logic [3:0]       press;
  logic             clear;
  logic             capture;
  logic             unused_sw;

`ifdef HOLD_TIMEOUT_EN
  localparam logic [31:0] HOLD_LAST = 32'(TIMEOUT_CYCLES);
  logic [31:0] hold_cnt_q, hold_cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

  // Lowest-numbered key wins, matching the datapath's operator priority.
  function automatic logic [1:0] encode_press(input logic [3:0] p);
    logic [1:0] code;
    code = 2'd3;
    if (p[2]) code = 2'd2;
    if (p[1]) code = 2'd1;
    if (p[0]) code = 2'd0;
    return code;
  endfunction

  assign unused_sw = sw_sync_q[8];

  always_comb begin
    key_meta_d = KEY;
    key_sync_d = key_meta_q;
    sw_meta_d  = SW;
    sw_sync_d  = sw_meta_q;
  end

  // Any cycle where the synced level agrees with the accepted level restarts the count.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      key_db_d[i] = key_db_q[i];
      if (key_sync_q[i] != key_db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST_M1) begin
          key_db_d[i] = key_sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign key_prev_d = key_db_q;
  assign press      = key_prev_q & ~key_db_q;
  assign clear      = sw_sync_q[9];

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|press) && !clear) begin
          capture = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (key_db_q == 4'b1111) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    op_valid_d  = op_valid_q;
    op_strobe_d = capture;
`ifdef HOLD_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    if (capture) begin
      hold_cnt_d = '0;
    end else if (op_valid_q) begin
      hold_cnt_d = hold_cnt_q + 32'd1;
    end
`endif
    if (capture) begin
      op_a_d     = sw_sync_q[3:0];
      op_b_d     = sw_sync_q[7:4];
      op_sel_d   = encode_press(press);
      op_valid_d = 1'b1;
    end else if (clear) begin
      op_a_d     = '0;
      op_b_d     = '0;
      op_sel_d   = '0;
      op_valid_d = 1'b0;
    end
`ifdef HOLD_TIMEOUT_EN
    else if (op_valid_q && (hold_cnt_q == HOLD_LAST)) begin
      op_a_d     = '0;
      op_b_d     = '0;
      op_sel_d   = '0;
      op_valid_d = 1'b0;
    end
`endif
  end

  // Key synchronizers reset to "released" so reset never fabricates a press.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta_q  <= 4'b1111;
      key_sync_q  <= 4'b1111;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      key_db_q    <= 4'b1111;
      key_prev_q  <= 4'b1111;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      op_valid_q  <= 1'b0;
      op_strobe_q <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      key_meta_q  <= key_meta_d;
      key_sync_q  <= key_sync_d;
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      key_db_q    <= key_db_d;
      key_prev_q  <= key_prev_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      op_valid_q  <= op_valid_d;
      op_strobe_q <= op_strobe_d;
`ifdef HOLD_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_sel    = op_sel_q;
  assign op_valid  = op_valid_q;
  assign op_strobe = op_strobe_q;

endmodule
